// File: rtl/rgb_to_gray_axis.sv
`default_nettype none
// ============================================================================
// Module   : rgb_to_gray_axis
// Brief    : Two-stage RGB888 -> 8-bit luma AXI-Stream converter with
//            per-frame pixel counting and sticky frame-length error flag.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_to_gray_axis #(
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] T_TOTAL_PIXELS,
  input  logic        gray_bypass,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        frame_done,
  output logic        len_err,
  output logic [31:0] pix_count
);

  localparam logic [15:0] c_coef_r = 16'(COEF_R);
  localparam logic [15:0] c_coef_g = 16'(COEF_G);
  localparam logic [15:0] c_coef_b = 16'(COEF_B);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CLOSE  = 2'd2
  } state_t;

  logic        w_ce;
  logic        w_accept;
  logic [15:0] w_sum;
  logic [7:0]  w_y;
  logic [31:0] w_cnt_inc;

  logic        v1_q, last1_q, byp1_q;
  logic [15:0] prod_r_q, prod_g_q, prod_b_q;
  logic [7:0]  g1_q;
  logic        v2_q, last2_q;
  logic [7:0]  y2_q;

  state_t      state_q, state_d;
  logic [31:0] pix_count_q, pix_count_d;
  logic [31:0] exp_len_q, exp_len_d;
  logic        len_err_q, len_err_d;

  // A single enable freezes both stages together, so a downstream stall never drops or repeats a beat.
  assign w_ce          = !v2_q || m_axis_tready;
  assign w_accept      = s_axis_tvalid && w_ce;
  assign s_axis_tready = w_ce;

  // Coefficients sum to 256, so the rounded sum tops out at 65408 and never overflows 16 bits.
  assign w_sum     = prod_r_q + prod_g_q + prod_b_q + 16'd128;
  assign w_y       = byp1_q ? g1_q : w_sum[15:8];
  assign w_cnt_inc = pix_count_q + 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      byp1_q   <= 1'b0;
      g1_q     <= '0;
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      y2_q     <= '0;
    end else if (w_ce) begin
      v1_q     <= s_axis_tvalid;
      last1_q  <= s_axis_tlast;
      byp1_q   <= gray_bypass;
      g1_q     <= s_axis_tdata[15:8];
      prod_r_q <= 16'(s_axis_tdata[23:16]) * c_coef_r;
      prod_g_q <= 16'(s_axis_tdata[15:8]) * c_coef_g;
      prod_b_q <= 16'(s_axis_tdata[7:0]) * c_coef_b;
      v2_q     <= v1_q;
      last2_q  <= last1_q;
      y2_q     <= w_y;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pix_count_q <= '0;
      exp_len_q   <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_count_q <= pix_count_d;
      exp_len_q   <= exp_len_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pix_count_d = pix_count_q;
    exp_len_d   = exp_len_q;
    len_err_d   = len_err_q;
    case (state_q)
      ST_STREAM: begin
        if (w_accept) begin
          pix_count_d = w_cnt_inc;
          if (s_axis_tlast) begin
            state_d = ST_CLOSE;
          end else if (w_cnt_inc == exp_len_q) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: begin
        // CLOSE finishes the old frame; a beat in the same cycle opens the next one exactly as IDLE would.
        if (state_q == ST_CLOSE) begin
          pix_count_d = '0;
          state_d     = ST_IDLE;
          if (pix_count_q != exp_len_q) begin
            len_err_d = 1'b1;
          end
        end
        if (w_accept) begin
          exp_len_d   = T_TOTAL_PIXELS;
          pix_count_d = 32'd1;
          state_d     = s_axis_tlast ? ST_CLOSE : ST_STREAM;
          if (!s_axis_tlast && (T_TOTAL_PIXELS == 32'd1)) begin
            len_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign m_axis_tdata  = y2_q;
  assign m_axis_tvalid = v2_q;
  assign m_axis_tlast  = last2_q;
  assign frame_done    = (state_q == ST_CLOSE);
  assign len_err       = len_err_q;
  assign pix_count     = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_gray_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_to_gray_axis
// Brief    : Self-checking bench for rgb_to_gray_axis with a luma/frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_to_gray_axis;

  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] T_TOTAL_PIXELS = '0;
  logic        gray_bypass = 1'b0;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        len_err;
  logic [31:0] pix_count;

  rgb_to_gray_axis #(.COEF_R(COEF_R), .COEF_G(COEF_G), .COEF_B(COEF_B)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .T_TOTAL_PIXELS (T_TOTAL_PIXELS),
    .gray_bypass    (gray_bypass),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .frame_done     (frame_done),
    .len_err        (len_err),
    .pix_count      (pix_count)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         fd_seen  = 0;
  int         fd_exp   = 0;
  int         n_out    = 0;
  int         rdy_mode = 0;
  logic       exp_len_err = 1'b0;
  logic [8:0] exp_q[$];
  logic [23:0] frame_pix[16];

  // Rounded luma from the weighted sum, or G straight through in bypass.
  function automatic logic [7:0] luma(input logic [23:0] p, input logic byp);
    int s;
    if (byp) return p[15:8];
    s = int'(p[23:16]) * COEF_R + int'(p[15:8]) * COEF_G + int'(p[7:0]) * COEF_B;
    return 8'((s + 128) / 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 stalled.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = !m_axis_tready;
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Scoreboard: queue accepted beats, compare emitted beats in order, watch stall stability.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (s_axis_tvalid && s_axis_tready)
          exp_q.push_back({luma(s_axis_tdata, gray_bypass), s_axis_tlast});
        if (prev_stall) begin
          chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
          chk("stall_hold", 32'({m_axis_tdata, m_axis_tlast}), 32'(prev_out));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_out++;
          if (exp_q.size() == 0) chk("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
          else chk("out_beat", 32'({m_axis_tdata, m_axis_tlast}), 32'(exp_q.pop_front()));
        end
        if (frame_done) fd_seen++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tdata, m_axis_tlast};
      end
    end
  end

  task automatic send(input logic [23:0] pix, input logic last, input logic byp, input int gap);
    int k;
    bit acc;
    k   = 0;
    acc = 1'b0;
    s_axis_tdata  = pix;
    s_axis_tlast  = last;
    gray_bypass   = byp;
    s_axis_tvalid = 1'b1;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_timeout", 32'(k < 500), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_end_checks(input string tag);
    chk({tag, "_len_err"}, 32'(len_err), 32'(exp_len_err));
    chk({tag, "_frame_done"}, 32'(fd_seen), 32'(fd_exp));
    chk({tag, "_pix_count"}, pix_count, 32'd0);
    chk({tag, "_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_frame(input int len, input int t, input int maxgap);
    T_TOTAL_PIXELS = 32'(t);
    for (int i = 1; i <= len; i++)
      send(24'($urandom), i == len, 1'($urandom_range(0, 1)), $urandom_range(0, maxgap));
    if (len != t) exp_len_err = 1'b1;
    fd_exp++;
  endtask

  initial begin
    logic [23:0] t1[5];
    int          n0;
    int          len;
    t1 = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_pix_count", pix_count, 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-pixel frames with latency checks
    T_TOTAL_PIXELS = 32'd1;
    for (int i = 0; i < 5; i++) begin
      send(t1[i], 1'b1, 1'b0, 0);
      fd_exp++;
      @(negedge clk);
      chk("lat1_valid", 32'(m_axis_tvalid), 32'd0);
      @(negedge clk);
      chk("lat2_valid", 32'(m_axis_tvalid), 32'd1);
      chk("lat2_data", 32'(m_axis_tdata), 32'(luma(t1[i], 1'b0)));
      chk("lat2_last", 32'(m_axis_tlast), 32'd1);
      @(posedge clk);
      #1;
    end
    drain();
    frame_end_checks("single");

    // 16-pixel frame at full rate
    for (int i = 0; i < 16; i++) frame_pix[i] = 24'($urandom);
    T_TOTAL_PIXELS = 32'd16;
    n0 = n_out;
    for (int i = 0; i < 16; i++) begin
      send(frame_pix[i], i == 15, 1'b0, 0);
      if (i == 7) chk("f16_mid_count", pix_count, 32'd8);
    end
    fd_exp++;
    drain();
    chk("f16_outputs", 32'(n_out - n0), 32'd16);
    frame_end_checks("f16");

    // Same frame, toggling ready and random input gaps
    rdy_mode = 1;
    n0 = n_out;
    for (int i = 0; i < 16; i++) send(frame_pix[i], i == 15, 1'b0, $urandom_range(0, 2));
    fd_exp++;
    drain();
    rdy_mode = 0;
    chk("f16s_outputs", 32'(n_out - n0), 32'd16);
    frame_end_checks("f16s");

    // Back-to-back 4-pixel frames
    T_TOTAL_PIXELS = 32'd4;
    for (int i = 0; i < 4; i++) send(24'($urandom), i == 3, 1'b0, 0);
    send(24'($urandom), 1'b0, 1'b0, 0);
    chk("b2b_restart_count", pix_count, 32'd1);
    for (int i = 1; i < 4; i++) send(24'($urandom), i == 3, 1'b0, 0);
    fd_exp += 2;
    drain();
    frame_end_checks("b2b");

    // Random frames under random backpressure, matching lengths
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, 20);
      rand_frame(len, len, 2);
    end
    drain();
    rdy_mode = 0;
    frame_end_checks("rand_ok");

    // Short frame, then a long frame with len_err already sticky
    T_TOTAL_PIXELS = 32'd16;
    for (int i = 1; i <= 12; i++) send(24'($urandom), i == 12, 1'b0, 0);
    fd_exp++;
    exp_len_err = 1'b1;
    drain();
    frame_end_checks("short");
    T_TOTAL_PIXELS = 32'd8;
    n0 = n_out;
    for (int i = 1; i <= 10; i++) send(24'($urandom), i == 10, 1'b0, 0);
    fd_exp++;
    drain();
    chk("long_outputs", 32'(n_out - n0), 32'd10);
    frame_end_checks("long");

    // Reset with both stages full and downstream stalled
    rdy_mode = 3;
    @(posedge clk);
    #1;
    T_TOTAL_PIXELS = 32'd4;
    send(24'h102030, 1'b0, 1'b0, 0);
    send(24'h405060, 1'b0, 1'b0, 0);
    chk("full_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("full_tready", 32'(s_axis_tready), 32'd0);
    chk("full_count", pix_count, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_count", pix_count, 32'd0);
    chk("arst_len_err", 32'(len_err), 32'd0);
    exp_len_err = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Bypass pixel after reset
    T_TOTAL_PIXELS = 32'd1;
    send(24'h123456, 1'b1, 1'b1, 0);
    fd_exp++;
    @(negedge clk);
    @(negedge clk);
    chk("byp_valid", 32'(m_axis_tvalid), 32'd1);
    chk("byp_data", 32'(m_axis_tdata), 32'h34);
    @(posedge clk);
    #1;

    // Post-reset frame with random bypass mix
    rand_frame(6, 6, 1);
    drain();
    frame_end_checks("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
